// File: rtl/sf_frac_expand.sv
// Expands a decoded product term (sign, scale factor, 1.f mantissa) into the
// segmented two's-complement accumulator format through a 3-stage valid/ready pipeline.
module sf_frac_expand #(
    parameter int WIDTH    = 8,
    parameter int K        = 9,
    parameter int EXP      = 2,
    parameter int ACC      = (2**EXP)*(WIDTH-2),
    parameter int MTS      = WIDTH-3-EXP,
    parameter int REGI     = $clog2(WIDTH)+1,
    parameter int ACC_HEAD = $clog2(K)+2
) (
    input  logic                  clk_i,
    input  logic                  rstn,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic                  sign_i,
    input  logic                  zero_i,
    input  logic [REGI+EXP:0]     sf_i,
    input  logic [2*MTS+1:0]      mts_i,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [ACC_HEAD-1:0]   acc_000_c,
    output logic [ACC-1:0]        acc_001_c,
    output logic [ACC-1:0]        acc_010_c,
    output logic [ACC-1:0]        acc_011_c,
    output logic [ACC-1:0]        acc_100_c,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam int SFW  = REGI+EXP+1;
    localparam int MW   = 2*MTS+2;
    localparam int BW   = 4*ACC;
    localparam int FW   = ACC_HEAD+BW;
    localparam int SH_W = $clog2(BW);
    localparam int PW   = ((SH_W > SFW) ? SH_W : SFW) + 2;

    localparam logic signed [PW-1:0] P_MAX = PW'(BW-1);
    localparam logic signed [PW-1:0] P_OFF = PW'(2*ACC);

    logic en;

    // Stage 1: classify and compute right-shift distance from the top body bit
    logic signed [PW-1:0] p_c;
    logic                 ovf_c;
    logic                 udf_c;
    logic                 kill_c;
    logic [SH_W-1:0]      rsh_c;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        p_c    = PW'($signed(sf_i)) + P_OFF;
        ovf_c  = 1'b0;
        udf_c  = 1'b0;
        rsh_c  = '0;
        if (!zero_i) begin
            ovf_c = (p_c > P_MAX);
            udf_c = p_c[PW-1];
        end
        kill_c = zero_i | ovf_c | udf_c;
        if (!kill_c) begin
            rsh_c = SH_W'(P_MAX - p_c);
        end
    end

    logic            s1_vld, s1_sign, s1_ovf, s1_udf;
    logic [SH_W-1:0] s1_rsh;
    logic [MW-1:0]   s1_mts;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value.
    // NOTE: data registers are reset along with the valids so outputs read 0 after reset.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_ovf  <= 1'b0;
            s1_udf  <= 1'b0;
            s1_rsh  <= '0;
            s1_mts  <= '0;
        end else if (en) begin
            s1_vld  <= in_vld;
            s1_sign <= sign_i & ~zero_i & ~udf_c;
            s1_ovf  <= ovf_c;
            s1_udf  <= udf_c;
            s1_rsh  <= rsh_c;
            s1_mts  <= kill_c ? '0 : mts_i;
        end
    end

    // Stage 2: barrel shift; mantissa starts at the top and bits below LSB fall off
    logic [BW-1:0] top_c;
    logic [FW-1:0] mag_c;

    always_comb begin
        top_c = {s1_mts, {(BW-MW){1'b0}}};
        mag_c = {{ACC_HEAD{1'b0}}, top_c >> s1_rsh};
        if (s1_ovf) begin
            mag_c = {{ACC_HEAD{1'b0}}, {BW{1'b1}}};
        end
    end

    logic          s2_vld, s2_sign, s2_ovf, s2_udf;
    logic [FW-1:0] s2_mag;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_ovf  <= 1'b0;
            s2_udf  <= 1'b0;
            s2_mag  <= '0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_ovf  <= s1_ovf;
            s2_udf  <= s1_udf;
            s2_mag  <= mag_c;
        end
    end

    // Stage 3: two's-complement negation across the full width, head included
    logic          s3_vld, s3_ovf, s3_udf;
    logic [FW-1:0] s3_f;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s3_vld <= 1'b0;
            s3_ovf <= 1'b0;
            s3_udf <= 1'b0;
            s3_f   <= '0;
        end else if (en) begin
            s3_vld <= s2_vld;
            s3_ovf <= s2_ovf;
            s3_udf <= s2_udf;
            s3_f   <= s2_sign ? (~s2_mag + FW'(1)) : s2_mag;
        end
    end

    assign en        = ~s3_vld | out_rdy;
    assign in_rdy    = en;
    assign out_vld   = s3_vld;
    assign ovf_o     = s3_ovf;
    assign udf_o     = s3_udf;
    assign acc_000_c = s3_f[FW-1 -: ACC_HEAD];
    assign acc_001_c = s3_f[4*ACC-1 -: ACC];
    assign acc_010_c = s3_f[3*ACC-1 -: ACC];
    assign acc_011_c = s3_f[2*ACC-1 -: ACC];
    assign acc_100_c = s3_f[ACC-1:0];

endmodule

// File: tb/tb_sf_frac_expand.sv
// Scoreboard bench for sf_frac_expand: accepted terms push model results,
// a negedge monitor pops and compares each delivered output.
module tb_sf_frac_expand;

    localparam int ACC  = 24;
    localparam int HEAD = 6;
    localparam int FW   = HEAD + 4*ACC;

    typedef struct {
        logic [FW-1:0] f;
        logic          ovf;
        logic          udf;
        int            cyc;
        int            stl;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rstn;
    logic            in_vld;
    logic            in_rdy;
    logic            sign_i;
    logic            zero_i;
    logic [6:0]      sf_i;
    logic [7:0]      mts_i;
    logic            out_vld;
    logic            out_rdy;
    logic [HEAD-1:0] acc_000_c;
    logic [ACC-1:0]  acc_001_c, acc_010_c, acc_011_c, acc_100_c;
    logic            ovf_o, udf_o;

    sf_frac_expand dut (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .sign_i    (sign_i),
        .zero_i    (zero_i),
        .sf_i      (sf_i),
        .mts_i     (mts_i),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .acc_000_c (acc_000_c),
        .acc_001_c (acc_001_c),
        .acc_010_c (acc_010_c),
        .acc_011_c (acc_011_c),
        .acc_100_c (acc_100_c),
        .ovf_o     (ovf_o),
        .udf_o     (udf_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   stl      = 0;
    exp_t sb[$];
    bit   rand_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Value of the term is (mts/128) * 2^sf; the accumulator integer is that times 2^48.
    function automatic exp_t model(input logic s, input logic z, input logic [6:0] sf, input logic [7:0] m);
        exp_t          e;
        int            sfv;
        int            sh;
        logic [FW-1:0] mag;
        sfv   = int'($signed(sf));
        e.ovf = 1'b0;
        e.udf = 1'b0;
        e.cyc = 0;
        e.stl = 0;
        mag   = '0;
        if (z) begin
            mag = '0;
        end else if (sfv >= 2*ACC) begin
            e.ovf = 1'b1;
            mag   = (FW'(1) << (4*ACC)) - FW'(1);
        end else if (sfv < -2*ACC) begin
            e.udf = 1'b1;
        end else begin
            sh  = sfv + 2*ACC - 7;
            mag = FW'(m);
            if (sh >= 0) mag = mag << sh;
            else         mag = mag >> (-sh);
        end
        e.f = s ? (FW'(0) - mag) : mag;
        return e;
    endfunction

    // Posedge bookkeeping: cycle count and cycles in which the pipeline was frozen
    always @(posedge clk_i) begin
        cyc++;
        if (out_vld && !out_rdy) stl++;
    end

    // Monitor
    logic [FW+1:0] snap;
    bit            held = 0;
    always @(negedge clk_i) begin
        logic [FW+1:0] cur;
        exp_t          e;
        cur = {ovf_o, udf_o, acc_000_c, acc_001_c, acc_010_c, acc_011_c, acc_100_c};
        if (!rstn) begin
            held = 0;
        end else begin
            check("in_rdy", in_rdy, !out_vld || out_rdy);
            if (held) begin
                check("hold_vld", out_vld, 1'b1);
                check("hold_data", cur, snap);
            end
            if (out_vld && !out_rdy) begin
                held = 1;
                snap = cur;
            end else begin
                held = 0;
            end
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) begin
                    check("spurious_out_vld", out_vld, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("segments", cur[FW-1:0], e.f);
                    check("ovf", ovf_o, e.ovf);
                    check("udf", udf_o, e.udf);
                    check("latency", (cyc - e.cyc) - (stl - e.stl), 3);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the term was taken
    task automatic send(input logic s, input logic z, input logic [6:0] sf, input logic [7:0] m);
        exp_t e;
        bit   ok;
        ok     = 0;
        sign_i = s;
        zero_i = z;
        sf_i   = sf;
        mts_i  = m;
        in_vld = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (in_rdy) ok = 1;
        end
        if (!ok) begin
            check("accept_timeout", in_rdy, 1'b1);
        end else begin
            e     = model(s, z, sf, m);
            e.cyc = cyc;
            e.stl = stl;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk_i);
        check("drain_empty", sb.size(), 0);
        #1;
    endtask

    task automatic check_cleared(input string name);
        check({name, "_vld"}, out_vld, 1'b0);
        check({name, "_seg"}, {acc_000_c, acc_001_c, acc_010_c, acc_011_c, acc_100_c}, '0);
        check({name, "_flags"}, {ovf_o, udf_o}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int v;
        rstn    = 1'b0;
        in_vld  = 1'b0;
        sign_i  = 1'b0;
        zero_i  = 1'b0;
        sf_i    = '0;
        mts_i   = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_cleared("reset");
        rstn = 1'b1;
        @(posedge clk_i);
        #1;
        check_cleared("post_reset");

        // Directed terms: unit values, fractions, range edges, zero priority
        send(1'b0, 1'b0, 7'd0,        8'h80);
        send(1'b1, 1'b0, 7'd0,        8'h80);
        send(1'b0, 1'b0, 7'(-1),      8'hC0);
        send(1'b0, 1'b0, 7'd47,       8'h80);
        send(1'b0, 1'b0, 7'd48,       8'h80);
        send(1'b1, 1'b0, 7'd48,       8'hA5);
        send(1'b0, 1'b0, 7'(-45),     8'hFF);
        send(1'b0, 1'b0, 7'(-48),     8'h80);
        send(1'b0, 1'b0, 7'(-49),     8'hFF);
        send(1'b0, 1'b0, 7'(-50),     8'h80);
        send(1'b1, 1'b1, 7'd60,       8'h80);
        send(1'b1, 1'b0, 7'(-64),     8'hFF);
        send(1'b1, 1'b0, 7'd63,       8'h80);
        drain();

        // Back-to-back stream with a downstream stall window
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(i[0], 1'b0, 7'(i * 7 - 20), 8'(8'h80 | (i * 19)));
            end
            begin
                repeat (3) @(posedge clk_i);
                #1 out_rdy = 1'b0;
                repeat (5) @(posedge clk_i);
                #1 out_rdy = 1'b1;
            end
        join
        drain();

        // Reset with terms in flight and one stalled at the output
        out_rdy = 1'b0;
        send(1'b0, 1'b0, 7'd3, 8'h90);
        send(1'b1, 1'b0, 7'd5, 8'hB0);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk_i);
            if (out_vld) ok = 1;
        end
        check("stalled_out_vld", out_vld, 1'b1);
        @(posedge clk_i);
        #2;
        rstn = 1'b0;
        #1;
        check_cleared("mid_reset");
        sb.delete();
        @(posedge clk_i);
        #1;
        rstn    = 1'b1;
        out_rdy = 1'b1;
        send(1'b1, 1'b0, 7'(-2), 8'hE0);
        drain();

        // Randomized stream with random backpressure and input gaps
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk_i);
                        #1;
                    end else begin
                        if ($urandom_range(0, 1) == 0) begin
                            v = int'($urandom_range(0, 104)) - 52;
                        end else begin
                            v = int'($urandom_range(0, 127)) - 64;
                        end
                        send(1'($urandom), ($urandom_range(0, 7) == 0), 7'(v), 8'(8'h80 | $urandom_range(0, 127)));
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk_i);
                    #1 out_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_rdy = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
